// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard unit: flush codes, mult/div FSM states
// and the RAW compare helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] CTL_PASS  = 2'b00;
    localparam logic [1:0] CTL_FLUSH = 2'b01;
    localparam logic [1:0] CTL_KEEP  = 2'b10;

    typedef enum logic {
        StRun  = 1'b0,
        StBusy = 1'b1
    } md_state_e;

    // Register $0 is hardwired to zero, so it can never create a dependency.
    function automatic logic raw_match(input logic       uses_rs,
                                       input logic       uses_rt,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [4:0] dst);
        return (dst != 5'd0) && ((uses_rs && (rs == dst)) || (uses_rt && (rt == dst)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Tracks a mult/div occupying HI/LO: RUN/BUSY FSM with a down-counter,
// md_busy is registered.
module md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    output logic md_busy
);

    localparam int unsigned CntW = $clog2(MD_LATENCY);
    localparam logic [CntW-1:0] CntLoad = CntW'(MD_LATENCY - 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            md_busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (md_start) begin
                    state_d = StBusy;
                    cnt_d   = CntLoad;
                end
            end
            StBusy: begin
                if (md_start) begin
                    cnt_d = CntLoad;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= (state_d == StBusy);
        end
    end

    assign md_busy = md_busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard unit for the 5-stage pipeline: flush codes, PC hold, stall counter.
// Define HAZARD_FWD_EN when EX/MEM->EX forwarding is present.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             id_is_md,
    input  logic             id_jump,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             branch_taken,
    input  logic             md_start,
    output logic [1:0]       if_id_ctl,
    output logic [1:0]       id_ex_ctl,
    output logic [1:0]       ex_mem_ctl,
    output logic [1:0]       mem_wb_ctl,
    output logic             pc_hold,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             raw_ex, raw_mem;
    logic             load_use, data_stall, md_stall, stall;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    md_busy_timer #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_busy_timer (
        .clk     (clk),
        .rst     (rst),
        .md_start(md_start),
        .md_busy (md_busy)
    );

    assign raw_ex  = raw_match(id_uses_rs, id_uses_rt, id_rs, id_rt, ex_rd);
    assign raw_mem = raw_match(id_uses_rs, id_uses_rt, id_rs, id_rt, mem_rd);

    assign load_use = ex_mem_read && ex_reg_write && raw_ex;
    assign md_stall = md_busy && (id_uses_hilo || id_is_md);

`ifdef HAZARD_FWD_EN
    logic unused_mem;
    assign unused_mem = raw_mem ^ mem_reg_write;
    assign data_stall = 1'b0;
`else
    // WB writes in the first half-cycle, so only EX and MEM producers matter.
    assign data_stall = (ex_reg_write && raw_ex) || (mem_reg_write && raw_mem);
`endif

    assign stall = load_use || data_stall || md_stall;

    always_comb begin
        if_id_ctl  = CTL_PASS;
        id_ex_ctl  = CTL_PASS;
        ex_mem_ctl = CTL_PASS;
        mem_wb_ctl = CTL_PASS;
        pc_hold    = 1'b0;
        if (rst) begin
            if_id_ctl  = CTL_FLUSH;
            id_ex_ctl  = CTL_FLUSH;
            ex_mem_ctl = CTL_FLUSH;
            mem_wb_ctl = CTL_FLUSH;
        end else if (branch_taken) begin
            // Wrong-path IF/ID contents are discarded, so a pending stall is moot.
            if_id_ctl = CTL_FLUSH;
            id_ex_ctl = CTL_FLUSH;
        end else if (stall) begin
            pc_hold   = 1'b1;
            if_id_ctl = CTL_KEEP;
            id_ex_ctl = CTL_FLUSH;
        end else if (id_jump) begin
            if_id_ctl = CTL_FLUSH;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_hold && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
